// File: rtl/a2d_arbiter.sv
// rtl/a2d_arbiter.sv - two-requester arbiter for the shared A2D SPI interface
//
// Purpose: holds one pending request per requester, grants the A2D interface
// by fixed (requester 0 first) or round-robin priority, issues a single
// conversion at a time and returns the completion pulse and the 12-bit
// result to the granted requester.
//
// Optional feature macro: A2D_ARB_TIMEOUT_EN (BUSY watchdog + timeout_err).
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   strt_cnv0/1, chnnl0/1     requester request pulses and channels
//   busy0/1                   requester has a request pending or in flight
//   cnv_cmplt0/1              one-cycle completion pulse to the granted requester
//   A2D_res                   registered result, held until the next completion
//   a2d_strt_cnv, a2d_chnnl   start pulse and channel to the A2D interface
//   a2d_cnv_cmplt, a2d_res    completion and result from the A2D interface
//   timeout_err               sticky abort flag (only with A2D_ARB_TIMEOUT_EN)

module a2d_arbiter #(
   parameter bit          RR_MODE = 1'b0,
   parameter logic [15:0] TIMEOUT = 16'd8191
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        strt_cnv0,
   input  logic [2:0]  chnnl0,
   input  logic        strt_cnv1,
   input  logic [2:0]  chnnl1,
   output logic        busy0,
   output logic        busy1,
   output logic        cnv_cmplt0,
   output logic        cnv_cmplt1,
   output logic [11:0] A2D_res,
   output logic        a2d_strt_cnv,
   output logic [2:0]  a2d_chnnl,
   input  logic        a2d_cnv_cmplt,
   input  logic [11:0] a2d_res
`ifdef A2D_ARB_TIMEOUT_EN
   ,
   output logic        timeout_err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_pend0;
   logic        r_pend1;
   logic [2:0]  r_ch0;
   logic [2:0]  r_ch1;
   logic        r_gnt;
   logic        r_last_gnt;
   logic [2:0]  r_chnnl;
   logic [11:0] r_res;
   logic        w_sel;
   logic        w_done;
   logic        w_abort;
   logic        w_clr0;
   logic        w_clr1;
   logic        w_acc0;
   logic        w_acc1;
   logic        w_pulse;

`ifdef A2D_ARB_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        r_to_pulse;
   logic        r_to_err;
`else
   localparam logic [15:0] unused_timeout = TIMEOUT;
`endif

   // Tie: fixed mode favours requester 0, RR mode favours whoever was not last.
   assign w_sel = r_pend0 ? (r_pend1 & RR_MODE & ~r_last_gnt) : 1'b1;

   always_comb begin
      w_next  = r_state;
      w_done  = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         S_IDLE:  if (r_pend0 | r_pend1) w_next = S_ISSUE;
         S_ISSUE: w_next = S_BUSY;
         S_BUSY: begin
            if (a2d_cnv_cmplt) begin
               w_done = 1'b1;
               w_next = S_DONE;
            end
`ifdef A2D_ARB_TIMEOUT_EN
            else if (r_cnt == TIMEOUT - 16'd1) begin
               w_abort = 1'b1;
               w_next  = S_IDLE;
            end
`endif
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_clr0 = (w_done | w_abort) & ~r_gnt;
   assign w_clr1 = (w_done | w_abort) &  r_gnt;
   // A request coinciding with its own completion clear is still accepted.
   assign w_acc0 = strt_cnv0 & (~r_pend0 | w_clr0);
   assign w_acc1 = strt_cnv1 & (~r_pend1 | w_clr1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pend0    <= 1'b0;
         r_pend1    <= 1'b0;
         r_ch0      <= 3'b000;
         r_ch1      <= 3'b000;
         r_gnt      <= 1'b0;
         r_last_gnt <= 1'b1;
         r_chnnl    <= 3'b000;
         r_res      <= 12'h000;
      end else begin
         r_state <= w_next;
         if (w_acc0) begin
            r_pend0 <= 1'b1;
            r_ch0   <= chnnl0;
         end else if (w_clr0) begin
            r_pend0 <= 1'b0;
         end
         if (w_acc1) begin
            r_pend1 <= 1'b1;
            r_ch1   <= chnnl1;
         end else if (w_clr1) begin
            r_pend1 <= 1'b0;
         end
         if (r_state == S_IDLE && (r_pend0 | r_pend1)) begin
            r_gnt   <= w_sel;
            r_chnnl <= w_sel ? r_ch1 : r_ch0;
         end
         if (r_state == S_ISSUE) r_last_gnt <= r_gnt;
         if (w_done) r_res <= a2d_res;
`ifdef A2D_ARB_TIMEOUT_EN
         if (w_abort) r_res <= 12'hFFF;
`endif
      end
   end

`ifdef A2D_ARB_TIMEOUT_EN
   // Abort jumps straight to IDLE, so its completion pulse is registered here
   // and appears in the IDLE cycle while r_gnt still names the aborted requester.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= 16'd0;
         r_to_pulse <= 1'b0;
         r_to_err   <= 1'b0;
      end else begin
         if (r_state == S_ISSUE)     r_cnt <= 16'd0;
         else if (r_state == S_BUSY) r_cnt <= r_cnt + 16'd1;
         r_to_pulse <= w_abort;
         if (w_abort) r_to_err <= 1'b1;
      end
   end
   assign timeout_err = r_to_err;
   assign w_pulse     = (r_state == S_DONE) | r_to_pulse;
`else
   assign w_pulse     = (r_state == S_DONE);
`endif

   assign busy0        = r_pend0;
   assign busy1        = r_pend1;
   assign cnv_cmplt0   = w_pulse & ~r_gnt;
   assign cnv_cmplt1   = w_pulse &  r_gnt;
   assign a2d_strt_cnv = (r_state == S_ISSUE);
   assign a2d_chnnl    = r_chnnl;
   assign A2D_res      = r_res;

endmodule

// File: tb/tb_a2d_arbiter.sv
// tb/tb_a2d_arbiter.sv - self-checking bench for a2d_arbiter (fixed and RR instances)

module tb_a2d_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  s0, s1, a_cmp;
   logic [2:0]  c0 [2];
   logic [2:0]  c1 [2];
   logic [11:0] a_res [2];
   logic [1:0]  o_busy0, o_busy1, o_cmp0, o_cmp1, o_strt, o_terr;
   logic [11:0] o_res [2];
   logic [2:0]  o_chnnl [2];
   int          n_cmp = 0;
   int          n_err = 0;
   int          m_last [2];

   always #5 clk = ~clk;

   a2d_arbiter #(.RR_MODE(1'b0), .TIMEOUT(16'd20)) u_fix (
      .clk(clk), .rst(rst),
      .strt_cnv0(s0[0]), .chnnl0(c0[0]), .strt_cnv1(s1[0]), .chnnl1(c1[0]),
      .busy0(o_busy0[0]), .busy1(o_busy1[0]),
      .cnv_cmplt0(o_cmp0[0]), .cnv_cmplt1(o_cmp1[0]),
      .A2D_res(o_res[0]), .a2d_strt_cnv(o_strt[0]), .a2d_chnnl(o_chnnl[0]),
      .a2d_cnv_cmplt(a_cmp[0]), .a2d_res(a_res[0])
`ifdef A2D_ARB_TIMEOUT_EN
      , .timeout_err(o_terr[0])
`endif
   );

   a2d_arbiter #(.RR_MODE(1'b1), .TIMEOUT(16'd20)) u_rr (
      .clk(clk), .rst(rst),
      .strt_cnv0(s0[1]), .chnnl0(c0[1]), .strt_cnv1(s1[1]), .chnnl1(c1[1]),
      .busy0(o_busy0[1]), .busy1(o_busy1[1]),
      .cnv_cmplt0(o_cmp0[1]), .cnv_cmplt1(o_cmp1[1]),
      .A2D_res(o_res[1]), .a2d_strt_cnv(o_strt[1]), .a2d_chnnl(o_chnnl[1]),
      .a2d_cnv_cmplt(a_cmp[1]), .a2d_res(a_res[1])
`ifdef A2D_ARB_TIMEOUT_EN
      , .timeout_err(o_terr[1])
`endif
   );

`ifndef A2D_ARB_TIMEOUT_EN
   assign o_terr = 2'b00;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Grant rule: fixed instance always prefers 0; RR instance prefers the non-last on a tie.
   function automatic int winner(input int k, input logic p0, input logic p1, input int last);
      if (p0 && p1) return (k == 1) ? ((last == 1) ? 0 : 1) : 0;
      return p0 ? 0 : 1;
   endfunction

   task automatic chk_rst(input int k);
      chk("rst_busy0", o_busy0[k], 0);
      chk("rst_busy1", o_busy1[k], 0);
      chk("rst_cmplt0", o_cmp0[k], 0);
      chk("rst_cmplt1", o_cmp1[k], 0);
      chk("rst_strt", o_strt[k], 0);
      chk("rst_chnnl", o_chnnl[k], 0);
      chk("rst_res", o_res[k], 0);
      chk("rst_terr", o_terr[k], 0);
   endtask

   task automatic drive_req(input int k, input int g, input logic [2:0] ch);
      if (g == 0) begin s0[k] = 1'b1; c0[k] = ch; end
      else        begin s1[k] = 1'b1; c1[k] = ch; end
   endtask

   // One transaction-level scenario: initial requests, optional duplicate
   // requests, then rr_n random re-requests issued at or just after completion.
   task automatic scen(input int k, input logic [1:0] mask, input logic [2:0] v0,
                       input logic [2:0] v1, input bit dup, input int rr_n);
      logic        mp [2];
      logic [2:0]  mc [2];
      logic [11:0] r;
      logic [2:0]  nc;
      int          g, t, lat, since, left;
      bit          same;
      left = rr_n;
      mp[0] = mask[0]; mp[1] = mask[1]; mc[0] = v0; mc[1] = v1;
      s0[k] = mask[0]; s1[k] = mask[1]; c0[k] = v0; c1[k] = v1;
      step; since = 1; s0[k] = 1'b0; s1[k] = 1'b0;
      if (dup) begin
         s0[k] = mask[0]; s1[k] = mask[1]; c0[k] = ~v0; c1[k] = ~v1;
         step; since++; s0[k] = 1'b0; s1[k] = 1'b0;
      end
      while (mp[0] || mp[1]) begin
         g = winner(k, mp[0], mp[1], m_last[k]);
         t = 0;
         while (!o_strt[k] && t < 20) begin step; t++; since++; end
         chk("issue_lat", since, 2);
         if (!o_strt[k]) return;
         chk("chnnl", o_chnnl[k], mc[g]);
         m_last[k] = g;
         lat = $urandom_range(1, 6);
         repeat (lat) begin
            step;
            chk("strt_1cyc", o_strt[k], 0);
            chk("chnnl_hold", o_chnnl[k], mc[g]);
         end
         r = 12'($urandom); a_cmp[k] = 1'b1; a_res[k] = r; same = 1'b0;
         if (left > 0 && $urandom_range(0, 1) == 1) begin
            same = 1'b1; nc = 3'($urandom); drive_req(k, g, nc); left--;
         end
         step;
         a_cmp[k] = 1'b0; s0[k] = 1'b0; s1[k] = 1'b0; a_res[k] = ~r;
         chk("cmplt_gnt", (g == 1) ? o_cmp1[k] : o_cmp0[k], 1);
         chk("cmplt_other", (g == 1) ? o_cmp0[k] : o_cmp1[k], 0);
         chk("res", o_res[k], r);
         chk("busy_gnt", (g == 1) ? o_busy1[k] : o_busy0[k], same);
         mp[g] = same;
         if (same) mc[g] = nc;
         since = 0;
         if (!same && left > 0 && $urandom_range(0, 1) == 1) begin
            nc = 3'($urandom); drive_req(k, g, nc); left--; mp[g] = 1'b1; mc[g] = nc;
         end
         a_cmp[k] = 1'($urandom_range(0, 1));   // stray completion while in DONE
         step; since = 1;
         a_cmp[k] = 1'b0; s0[k] = 1'b0; s1[k] = 1'b0;
         chk("one_pulse", o_cmp0[k] | o_cmp1[k], 0);
         chk("res_held", o_res[k], r);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b1; s0 = '0; s1 = '0; a_cmp = '0;
      for (int k = 0; k < 2; k++) begin
         c0[k] = '0; c1[k] = '0; a_res[k] = '0; m_last[k] = 1;
      end
      repeat (3) @(posedge clk);
      #1;
      chk_rst(0);
      chk_rst(1);
      rst = 1'b0;
      step;

      scen(0, 2'b01, 3'b100, 3'b000, 1'b0, 0);
      scen(0, 2'b11, 3'b001, 3'b110, 1'b0, 0);
      scen(0, 2'b01, 3'b010, 3'b000, 1'b1, 0);
      scen(1, 2'b11, 3'b001, 3'b110, 1'b0, 2);
      for (int i = 0; i < 30; i++)
         for (int k = 0; k < 2; k++)
            scen(k, 2'($urandom_range(1, 3)), 3'($urandom), 3'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));

      // Reset while BUSY, then a late completion that must be ignored.
      s0[0] = 1'b1; c0[0] = 3'b101;
      step; s0[0] = 1'b0;
      t = 0;
      while (!o_strt[0] && t < 20) begin step; t++; end
      chk("mid_issue", o_strt[0], 1);
      step; step;
      rst = 1'b1;
      step; step;
      rst = 1'b0; m_last[0] = 1; m_last[1] = 1;
      step;
      a_cmp = 2'b11;
      step;
      a_cmp = 2'b00;
      repeat (4) begin
         chk_rst(0);
         chk_rst(1);
         step;
      end

`ifdef A2D_ARB_TIMEOUT_EN
      s0[0] = 1'b1; c0[0] = 3'b011;
      step; s0[0] = 1'b0;
      t = 0;
      while (!o_cmp0[0] && t < 60) begin step; t++; end
      chk("to_pulse", o_cmp0[0], 1);
      chk("to_res", o_res[0], 12'hFFF);
      chk("to_err", o_terr[0], 1);
      chk("to_busy", o_busy0[0], 0);
      step;
      scen(0, 2'b01, 3'b110, 3'b000, 1'b0, 0);
      chk("to_err_sticky", o_terr[0], 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/a2d_arbiter.md
# a2d_arbiter

Shares the single A2D SPI interface between two requesters: requester 0 is the motion controller (IR sensor round robin), requester 1 is an auxiliary monitor (battery/diagnostic channel). The arbiter holds at most one pending request per requester, grants the A2D interface by fixed or round-robin priority, issues one `strt_cnv` at a time, and routes `cnv_cmplt` and the 12-bit result back to the granted requester. It sits between the requesters and the A2D interface block.

## Interface
- `RR_MODE`, default 0: 0 gives requester 0 fixed priority; 1 alternates grants when both requesters are pending.
- `TIMEOUT`, default 16'd8191: cycles allowed in BUSY before abort. Used only with `A2D_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: **asynchronous, active-high** reset.
- `strt_cnv0` in 1: requester 0 one-cycle request pulse.
- `chnnl0` in 3: requester 0 channel, sampled with `strt_cnv0`.
- `strt_cnv1` in 1: requester 1 one-cycle request pulse.
- `chnnl1` in 3: requester 1 channel, sampled with `strt_cnv1`.
- `busy0`, `busy1` out 1 each: requester has a request pending or in flight.
- `cnv_cmplt0`, `cnv_cmplt1` out 1 each: one-cycle completion pulse to the granted requester.
- `A2D_res` out 12: registered result; valid with either `cnv_cmplt*` pulse and held until the next completion.
- `a2d_strt_cnv` out 1: one-cycle start pulse to the A2D interface.
- `a2d_chnnl` out 3: channel to the A2D interface; held stable from the issue cycle through completion.
- `a2d_cnv_cmplt` in 1: conversion done from the A2D interface.
- `a2d_res` in 12: conversion result from the A2D interface.
- `timeout_err` out 1: sticky abort flag. Present only with the macro.

## Operation
- **Pending registers:** `pend0`/`pend1` and `ch0`/`ch1`.
  - `strt_cnv*` with the matching `pend*` = 0 sets `pend*` and latches the channel.
  - `strt_cnv*` with the matching `pend*` = 1 is ignored; the original channel is kept.
  - `busy* = pend*`. `pend*` clears on that requester's completion.
- **State IDLE:**
  - If any `pend*` is set, select the grant, register `gnt`, load `a2d_chnnl`, and go to ISSUE.
  - Fixed mode (`RR_MODE` = 0): requester 0 wins.
  - RR mode: when both are pending, the requester that is not `last_gnt` wins. `last_gnt` resets to 1, so requester 0 wins the first tie.
- **State ISSUE:** assert `a2d_strt_cnv` for one cycle, update `last_gnt`, go to BUSY.
- **State BUSY:** on `a2d_cnv_cmplt`, capture `a2d_res` into `A2D_res`, clear `pend[gnt]`, go to DONE.
- **State DONE:** pulse `cnv_cmplt[gnt]` for one cycle, go to IDLE.
- **Illegal state:** go to IDLE.
- **Stray completion:** `a2d_cnv_cmplt` in IDLE, ISSUE or DONE is ignored.
- **Simultaneous events:** a request arriving in the same cycle as its own completion clear is accepted, because the clear takes effect first and the new request then sets `pend*`.

## Timing
- **Reset values:** `busy*`, `cnv_cmplt*`, `a2d_strt_cnv` and `timeout_err` = 0; `A2D_res` = 12'h000; `a2d_chnnl` = 3'b000; state IDLE; `last_gnt` = 1.
- **Request to start:** request pulse at cycle T with the arbiter idle gives `pend` at T+1, ISSUE at T+2, and `a2d_strt_cnv` high during T+2.
- **Completion to requester:** `a2d_cnv_cmplt` at cycle C gives `cnv_cmplt*` and valid `A2D_res` at C+1, and IDLE at C+2.
- **Back-to-back:** a second pending request issues `a2d_strt_cnv` at C+3.
- **Reset mid-conversion:** all pending requests are dropped and no completion pulse is produced. A late `a2d_cnv_cmplt` after reset arrives in IDLE and is ignored.

## Configuration
- **`A2D_ARB_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on entry to BUSY and increments every BUSY cycle.
  - Reaching `TIMEOUT` forces IDLE and clears `pend[gnt]`.
  - It also pulses `cnv_cmplt[gnt]` with `A2D_res` = 12'hFFF and sets `timeout_err`, which stays set until reset.
- **`A2D_ARB_TIMEOUT_EN` not defined:** no counter and no `timeout_err` port; BUSY waits indefinitely.

## Test plan
- **Single request:** `strt_cnv0` with `chnnl0`=3'b100 at T → `a2d_strt_cnv` at T+2 with `a2d_chnnl`=3'b100; `a2d_res`=12'hABC with `a2d_cnv_cmplt` at C → `cnv_cmplt0` at C+1 with `A2D_res`=12'hABC; `busy0` low at C+1; `cnv_cmplt1` stays 0.
- **Simultaneous, fixed priority:** `strt_cnv0` with chnnl 3'b001 and `strt_cnv1` with chnnl 3'b110 in the same cycle, `RR_MODE`=0 → requester 0 served first, then requester 1; `a2d_chnnl` sequence 001 then 110.
- **Round robin:** `RR_MODE`=1, both requesters re-request on every completion for 4 conversions → grant order 0,1,0,1.
- **Duplicate request:** `strt_cnv0` chnnl 3'b010, then `strt_cnv0` chnnl 3'b111 while `busy0` is high → exactly one conversion, on 3'b010.
- **Reset mid-conversion:** assert `rst` in BUSY, then release, then pulse `a2d_cnv_cmplt` → no `cnv_cmplt*` pulse; all outputs at reset values.
- **Timeout (macro defined):** `TIMEOUT`=20 and no `a2d_cnv_cmplt` → `cnv_cmplt0` pulse with `A2D_res`=12'hFFF, `timeout_err`=1, and the next request proceeds normally.
